// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
// Mode/direction encodings, FSM states and the per-step fill rule.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_LOGIC     = 2'b00,
        MODE_ROT       = 2'b01,
        MODE_ARITH     = 2'b10,
        MODE_LOGIC_ALT = 2'b11
    } mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Bit entering the register on one step; mode 11 behaves as logical.
    function automatic logic step_fill(
        input logic [1:0] mode,
        input logic       dir,
        input logic       msb,
        input logic       lsb,
        input logic       sin
    );
        logic f;
        unique case (1'b1)
            mode == MODE_ROT:   f = (dir == DIR_LEFT) ? msb : lsb;
            mode == MODE_ARITH: f = (dir == DIR_LEFT) ? 1'b0 : msb;
            default:            f = sin;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Single-position shift: next register value and the expelled bit.
// Shared by the single-step, iterative and barrel-reference paths.
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_o
);

    logic fill;

    assign fill = step_fill(mode_i, dir_i, q_i[WIDTH-1], q_i[0], serial_i);

    always_comb begin
        if (dir_i == DIR_LEFT) begin
            q_o   = {q_i[WIDTH-2:0], fill};
            out_o = q_i[WIDTH-1];
        end else begin
            q_o   = {fill, q_i[WIDTH-1:1]};
            out_o = q_i[0];
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with load, single-step and multi-shift.
// Define SHIFT_REG_UNIV_BARREL_EN to finish multi-shifts in one step.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               so_q, so_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   step_q;
    logic               step_so;
    logic [WIDTH-1:0]   multi_q;
    logic               multi_so;
    logic               multi_last;

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i      (q_q),
        .dir_i    (dir),
        .mode_i   (mode),
        .serial_i (serial_in),
        .q_o      (step_q),
        .out_o    (step_so)
    );

`ifdef SHIFT_REG_UNIV_BARREL_EN
    logic [2*WIDTH-1:0] ext;
    logic               bfill;
    int unsigned        n;
    int unsigned        r;

    // Past WIDTH+1 steps logical/arith results stop changing.
    always_comb begin
        n = int'(cnt_q);
        if (n > WIDTH + 1) n = WIDTH + 1;
        if (n == 0) n = 1;
        r = int'(cnt_q) % WIDTH;
        bfill = step_fill(mode, dir, q_q[WIDTH-1], q_q[0], serial_in);
        ext = {q_q, q_q};
        multi_q = q_q;
        multi_so = so_q;
        if (mode == MODE_ROT) begin
            if (dir == DIR_LEFT) begin
                ext = ext << r;
                multi_q = ext[2*WIDTH-1:WIDTH];
                multi_so = multi_q[0];
            end else begin
                ext = ext >> r;
                multi_q = ext[WIDTH-1:0];
                multi_so = multi_q[WIDTH-1];
            end
        end else if (dir == DIR_LEFT) begin
            ext = {q_q, {WIDTH{bfill}}};
            ext = ext << (n - 1);
            multi_so = ext[2*WIDTH-1];
            ext = ext << 1;
            multi_q = ext[2*WIDTH-1:WIDTH];
        end else begin
            ext = {{WIDTH{bfill}}, q_q};
            ext = ext >> (n - 1);
            multi_so = ext[0];
            ext = ext >> 1;
            multi_q = ext[WIDTH-1:0];
        end
    end

    assign multi_last = 1'b1;
`else
    assign multi_q    = step_q;
    assign multi_so   = step_so;
    assign multi_last = (cnt_q == AMT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            so_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            so_q    <= so_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SHIFT: begin
                if (load) state_d = IDLE;
                else if (multi_last) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                if (!load && start)
                    state_d = (amount != '0) ? SHIFT : DONE;
            end
        endcase
    end

    always_comb begin
        q_d   = q_q;
        so_d  = so_q;
        cnt_d = cnt_q;
        if (state_q == SHIFT) begin
            if (load) begin
                q_d   = load_data;
                cnt_d = '0;
            end else begin
                q_d   = multi_q;
                so_d  = multi_so;
`ifdef SHIFT_REG_UNIV_BARREL_EN
                cnt_d = '0;
`else
                cnt_d = cnt_q - AMT_W'(1);
`endif
            end
        end else if (load) begin
            q_d = load_data;
        end else if (start) begin
            cnt_d = amount;
        end else if (shift_en) begin
            q_d  = step_q;
            so_d = step_so;
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign q          = q_q;
    assign serial_out = so_q;

endmodule
